store_unit: RTL and testbench
=============================

# store_unit

Multicycle store path for the CPU datapath: accepts a store request (address, data, size) from the control unit, performs a read-modify-write on the shared word memory for byte and halfword stores, and writes full words directly. It is the writing counterpart of the instruction/data fetch path (PC → memory → instruction register). It owns the memory address, write-enable and write-data lines while busy. Completion and misalignment are reported back to the control unit.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, memory word width; fixed at 32 (four byte lanes)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req  in  1  store request; sampled only in IDLE
- req_addr  in  ADDR_W  byte address of the store
- req_data  in  DATA_W  store data, right-aligned (sb uses [7:0], sh uses [15:0])
- req_size  in  2  00 = word, 01 = half, 10 = byte, 11 = illegal
- busy  out  1  high from the cycle after acceptance until done/err
- done  out  1  one-cycle pulse: store finished (also pulses with err)
- err  out  1  one-cycle pulse: misaligned or illegal size, no write performed
- mem_addr  out  ADDR_W  word address to memory, {addr[ADDR_W-1:2], 2'b00}
- mem_wr  out  1  memory write enable
- mem_wdata  out  DATA_W  word written to memory
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented

## Operation
- States: IDLE, RD, LATCH, WR, FIN.
- IDLE: if req=1, latch req_addr/req_data/req_size. Illegal size, sh with addr[0]=1, or sw with addr[1:0]≠0 → FIN with err flag set. Legal sw → WR. Legal sb/sh → RD.
- RD: drive mem_addr, mem_wr=0. → LATCH.
- LATCH: sample mem_rdata into the merge register. → WR.
- WR: mem_wr=1. mem_wdata is req_data for sw, or the merge register with the addressed lane(s) replaced otherwise. → FIN.
- FIN: done=1, err=error flag. → IDLE. The next req can be accepted in the following cycle.
- Lane map (little-endian): addr[1:0]=0 → [7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24]. Half at addr[1]=0 → [15:0], at addr[1]=1 → [31:16]. Unaddressed bytes are preserved bit-exact.
- req in any state other than IDLE is ignored, with no queueing. Request inputs are don't-care after acceptance.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, err=0, mem_wr=0, mem_addr=0, mem_wdata=0, merge register=0. A store interrupted by reset never writes.

## Timing
- Cycle 0 is the edge on which req is sampled in IDLE.
- sw: WR in cycle 1, done in cycle 2. Latency 2 cycles; 1 memory access.
- sb/sh: RD in cycle 1, LATCH in cycle 2, WR in cycle 3, done in cycle 4. Latency 4 cycles; 2 memory accesses.
- Error: FIN in cycle 1 with done=err=1. mem_wr is never asserted.
- busy=1 in every non-IDLE state, including FIN.
- mem_wr is high for exactly one cycle per legal store and is registered/state-decoded with no glitch.
- mem_addr is held stable from RD through WR.

## Structure
- Shared package store_pkg holds:
  - size encodings SZ_WORD, SZ_HALF, SZ_BYTE, SZ_BAD
  - state enum (IDLE, RD, LATCH, WR, FIN)
- Sub-module store_merge (combinational): inputs old word, req_data, size, addr[1:0]; output merged word. It is shared with a later sub-word load unit for lane selection.
- The FSM, request latches and merge register live in the top module.

## Test plan
- Memory[0x100]=0xAABBCCDD; sb addr 0x101, data 0x11223344 → one mem_wr in cycle 3 with wdata 0xAABB44DD, done in cycle 4, err=0.
- Same preset; sh addr 0x102, data 0x00005566 → wdata 0x5566CCDD in cycle 3, done in cycle 4.
- sw addr 0x104, data 0xDEADBEEF → mem_wr in cycle 1 with mem_addr 0x104, wdata 0xDEADBEEF; done in cycle 2.
- sh addr 0x103, sw addr 0x102, or size 11 → done=err=1 in cycle 1, mem_wr stays 0, memory unchanged.
- sb accepted, reset pulled low during LATCH → all outputs 0 immediately, no mem_wr, memory unchanged; after release a new sw completes normally.
- req held high for 6 cycles with a sb → exactly one store is performed. A second request presented the cycle after done is accepted.

Source files
------------

// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - size encodings and FSM states for the store path
package store_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    WR    = 3'd3,
    FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - replaces the addressed little-endian lane(s) of a word
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_WORD: merged_o = data_i;
      SZ_HALF: begin
        if (lane_i[1]) merged_o[31:16] = data_i[15:0];
        else           merged_o[15:0]  = data_i[15:0];
      end
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = data_i[7:0];
          2'd1:    merged_o[15:8]  = data_i[7:0];
          2'd2:    merged_o[23:16] = data_i[7:0];
          default: merged_o[31:24] = data_i[7:0];
        endcase
      end
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - multicycle store with read-modify-write for byte/half stores
module store_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              busy_q, done_q, err_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] data_q, merge_q;
  logic [1:0]        size_q, lane_q;
  logic              bad_d;

  assign bad_d = (req_size == SZ_BAD)
              || (req_size == SZ_HALF && req_addr[0])
              || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

  // Write data is always derived from registers; after reset the word size
  // and zeroed data register make it read as 0 without a separate clear.
  store_merge u_merge (
    .old_i    (merge_q),
    .data_i   (data_q),
    .size_i   (size_q),
    .lane_i   (lane_q),
    .merged_o (mem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= '0;
      merge_q    <= '0;
      size_q     <= SZ_WORD;
      lane_q     <= 2'b00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            busy_q     <= 1'b1;
            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            data_q     <= req_data;
            size_q     <= req_size;
            lane_q     <= req_addr[1:0];
            merge_q    <= '0;
            if (bad_d) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state_q  <= WR;
              mem_wr_q <= 1'b1;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: state_q <= LATCH;
        LATCH: begin
          merge_q  <= mem_rdata;
          mem_wr_q <= 1'b1;
          state_q  <= WR;
        end
        WR: begin
          mem_wr_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= FIN;
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          mem_wr_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        busy, done, err, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:255];
  logic        preset_en = 1'b0;
  logic [31:0] preset_a = '0;
  logic [31:0] preset_v = '0;

  logic [63:0] sb_q[$];
  int checks = 0;
  int failures = 0;

  store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[9:2]];
    if (preset_en)   mem[preset_a[9:2]] <= preset_v;
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    @(posedge clk);
    #1 preset_a = a; preset_v = v; preset_en = 1'b1;
    @(posedge clk);
    #1 preset_en = 1'b0;
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] m, v;
    if (sz == 2'b10) begin
      m = 32'hFF << (8 * lo);
      v = (d & 32'hFF) << (8 * lo);
    end else if (sz == 2'b01) begin
      m = 32'hFFFF << (16 * lo[1]);
      v = (d & 32'hFFFF) << (16 * lo[1]);
    end else begin
      m = 32'hFFFF_FFFF;
      v = d;
    end
    return (old & ~m) | (v & m);
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input bit hold, input string tag);
    logic        bad, got_err;
    logic [31:0] wa, exp_w;
    logic [63:0] e;
    int          exp_done, got_done, wr_cnt, wr_cyc;
    wa  = {a[31:2], 2'b00};
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
    exp_w = ref_merge(mem[wa[9:2]], d, sz, a[1:0]);
    if (!bad) sb_q.push_back({wa, exp_w});
    exp_done = bad ? 1 : (sz == 2'b00 ? 2 : 4);
    @(posedge clk);
    #1 req = 1'b1; req_addr = a; req_data = d; req_size = sz;
    @(posedge clk);
    #1 if (!hold) begin
      req = 1'b0; req_data = $urandom; req_size = 2'($urandom);
    end
    got_done = 0; got_err = 1'b0; wr_cnt = 0; wr_cyc = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk({tag, ":busy"}, 32'(busy), 32'd1);
      if (mem_wr) begin
        wr_cnt++;
        wr_cyc = n;
        if (sb_q.size() == 0) chk({tag, ":unexpected_wr"}, 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk({tag, ":mem_addr"}, mem_addr, e[63:32]);
          chk({tag, ":mem_wdata"}, mem_wdata, e[31:0]);
        end
      end
      if (done) begin
        got_done = n;
        got_err  = err;
        break;
      end
      @(posedge clk);
    end
    req = 1'b0;
    chk({tag, ":done_cycle"}, 32'(got_done), 32'(exp_done));
    chk({tag, ":err"}, 32'(got_err), 32'(bad));
    chk({tag, ":wr_count"}, 32'(wr_cnt), bad ? 32'd0 : 32'd1);
    if (!bad) chk({tag, ":wr_cycle"}, 32'(wr_cyc), sz == 2'b00 ? 32'd1 : 32'd3);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:mem_wr", 32'(mem_wr), 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    preset(32'h100, 32'hAABBCCDD);
    preset(32'h104, 32'h0);
    do_store(32'h101, 32'h11223344, 2'b10, 1'b0, "sb101");
    chk("sb101:mem", mem[8'h40], 32'hAABB44DD);
    preset(32'h100, 32'hAABBCCDD);
    do_store(32'h102, 32'h00005566, 2'b01, 1'b0, "sh102");
    chk("sh102:mem", mem[8'h40], 32'h5566CCDD);
    do_store(32'h104, 32'hDEADBEEF, 2'b00, 1'b0, "sw104");
    chk("sw104:mem", mem[8'h41], 32'hDEADBEEF);

    preset(32'h100, 32'hAABBCCDD);
    do_store(32'h103, 32'h1234, 2'b01, 1'b0, "err_sh103");
    do_store(32'h102, 32'h12345678, 2'b00, 1'b0, "err_sw102");
    do_store(32'h100, 32'h12345678, 2'b11, 1'b0, "err_sz11");
    chk("err:mem", mem[8'h40], 32'hAABBCCDD);

    // byte store interrupted by reset while in LATCH
    @(posedge clk);
    #1 req = 1'b1; req_addr = 32'h100; req_data = 32'h99; req_size = 2'b10;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst:busy", 32'(busy), 32'd0);
    chk("arst:mem_wr", 32'(mem_wr), 32'd0);
    chk("arst:mem_addr", mem_addr, 32'd0);
    chk("arst:mem_wdata", mem_wdata, 32'd0);
    chk("arst:done_err", {30'd0, done, err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("arst:mem", mem[8'h40], 32'hAABBCCDD);
    do_store(32'h108, 32'hCAFEF00D, 2'b00, 1'b0, "post_rst_sw");
    chk("post_rst_sw:mem", mem[8'h42], 32'hCAFEF00D);

    do_store(32'h102, 32'h000000EE, 2'b10, 1'b1, "hold_sb");
    do_store(32'h100, 32'h00000077, 2'b10, 1'b0, "b2b_sb");
    chk("hold:mem", mem[8'h40], 32'hAAEECC77);

    for (int i = 0; i < 8; i++) preset(32'h200 + 32'(4 * i), $urandom);
    for (int i = 0; i < 12; i++)
      do_store(32'h200 + 32'($urandom_range(0, 31)), $urandom, 2'($urandom), 1'b0, "rand");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
